util_cpack2_timestamp_sched: RTL



---
 rtl/util_cpack2_timestamp_sched.sv | 125 ++++++++++++
 1 files changed

// File: rtl/util_cpack2_timestamp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : util_cpack2_timestamp_sched                                      |
// | Purpose : Write-port scheduler for the timestamped packed FIFO. Interleaves|
// |           64-bit timestamp headers with blocks of timestamp_every sample   |
// |           words and aborts the open block on downstream overflow.          |
// | Option  : `define UTIL_CPACK2_TIMESTAMP_SCHED_DROP_COUNT_EN adds a 16-bit  |
// |           saturating abort_count output.                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module util_cpack2_timestamp_sched #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   dma_clk,
  input  logic                   dma_resetn,
  input  logic [63:0]            timestamp,
  input  logic [COUNT_WIDTH-1:0] timestamp_every,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_sync,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   wr_en,
  output logic                   wr_sync,
  output logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_overflow,
  output logic                   block_active
`ifdef UTIL_CPACK2_TIMESTAMP_SCHED_DROP_COUNT_EN
  ,
  output logic [15:0]            abort_count
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [COUNT_WIDTH-1:0] r_n_latched;

  logic                   w_pass;
  logic [DATA_WIDTH-1:0]  w_ts_ext;

  // Passthrough mode: idle with timestamping disabled by the latched block length
  assign w_pass = (r_state == ST_IDLE) && (r_n_latched == '0);

  // Samples are consumed in passthrough, or inside a block unless it is being aborted
  assign s_ready = dma_resetn &&
                   (w_pass || ((r_state == ST_DATA) && !wr_overflow));

  assign block_active = (r_state == ST_DATA);

  // Header word is the timestamp zero-extended to the data width
  always_comb begin
    w_ts_ext       = '0;
    w_ts_ext[63:0] = timestamp;
  end

  // Scheduler FSM with registered write-port outputs
  always_ff @(posedge dma_clk or negedge dma_resetn) begin
    if (!dma_resetn) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_n_latched <= '0;
      wr_en       <= 1'b0;
      wr_sync     <= 1'b0;
      wr_data     <= '0;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Block length is re-sampled every idle cycle, frozen while in a block
          r_n_latched <= timestamp_every;
          if (w_pass) begin
            if (s_valid) begin
              wr_en   <= 1'b1;
              wr_data <= s_data;
              wr_sync <= s_sync;
            end
          end else if (s_valid) begin
            // Sample is held back; the header goes out first and carries sync
            wr_en       <= 1'b1;
            wr_data     <= w_ts_ext;
            wr_sync     <= 1'b1;
            r_remaining <= r_n_latched;
            r_state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wr_overflow) begin
            // Abort: the next block restarts with a fresh header
            r_state <= ST_IDLE;
          end else if (s_valid) begin
            wr_en   <= 1'b1;
            wr_data <= s_data;
            wr_sync <= 1'b0;
            if (r_remaining > 1) begin
              r_remaining <= r_remaining - 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UTIL_CPACK2_TIMESTAMP_SCHED_DROP_COUNT_EN
  // Saturating count of cycles in which an open block was aborted
  always_ff @(posedge dma_clk or negedge dma_resetn) begin
    if (!dma_resetn) begin
      abort_count <= 16'h0000;
    end else if ((r_state == ST_DATA) && wr_overflow && (abort_count != 16'hFFFF)) begin
      abort_count <= abort_count + 16'h0001;
    end
  end
`endif

endmodule
`default_nettype wire
